// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI program loader.
package spi_loader_pkg;

  // Frame/loader states. DONE is absorbing once the terminator word arrives.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    HOLD,
    DONE
  } loader_state_e;

  // Default terminator word that ends a load.
  localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;

endpackage

// File: rtl/spi_loader_shift.sv
// Serial-in shift register with bit counter. Raises word_valid_o for one cycle
// after the edge that samples the last bit, while word_o holds the full word.
module spi_loader_shift
  import spi_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  shift_en_i,
  input  logic                  mosi_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_bit_o,
  output logic                  word_valid_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  valid_q, valid_d;

  // Next-state for shift register, counter and the completion pulse.
  always_comb begin
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    last_bit_o = shift_en_i && (cnt_q == CntW'(DATA_WIDTH - 1));
    valid_d    = last_bit_o;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_i};
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = shreg_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/spi_prog_loader.sv
// Serial program loader: frames 32-bit words from spi_ss/spi_mosi and writes
// them through a one-entry buffered port to consecutive SRAM word addresses.
module spi_prog_loader
  import spi_loader_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] END_WORD   = DATA_WIDTH'(END_WORD_DEF)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam logic [ADDR_WIDTH:0] Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e         state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_eff;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  grant;
  logic                  shift_clear;
  logic                  shift_en;
  logic                  last_bit;
  logic                  word_valid;
  logic                  is_end;
  logic [DATA_WIDTH-1:0] word;

  assign grant       = req_q & mem_gnt_i;
  assign shift_clear = (state_q == ARM);
  assign shift_en    = (state_q == SHIFT) && !spi_ss;
  assign is_end      = word_valid && (word == END_WORD);

  spi_loader_shift #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (shift_clear),
    .shift_en_i  (shift_en),
    .mosi_i      (spi_mosi),
    .word_o      (word),
    .last_bit_o  (last_bit),
    .word_valid_o(word_valid)
  );

  // Frame FSM next-state; the terminator overrides everything and parks in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!spi_ss) state_d = ARM;
      ARM:     state_d = spi_ss ? IDLE : SHIFT;
      SHIFT: begin
        if (spi_ss)        state_d = IDLE;
        else if (last_bit) state_d = HOLD;
      end
      HOLD:    if (spi_ss) state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (is_end) state_d = DONE;
  end

  // Pending buffer, pointer and sticky flags.
  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    // A grant this cycle retires the pending write before a new word is judged.
    cnt_eff = cnt_q + {{ADDR_WIDTH{1'b0}}, grant};

    if (grant) begin
      req_d = 1'b0;
      cnt_d = cnt_eff;
    end

    if ((state_q == SHIFT) && spi_ss) err_d = 1'b1;

    if (word_valid) begin
      if (is_end) begin
        done_d = 1'b1;
      end else if (cnt_eff == Capacity) begin
        err_d = 1'b1;
      end else if (!req_q || grant) begin
        req_d   = 1'b1;
        addr_d  = cnt_eff[ADDR_WIDTH-1:0];
        wdata_d = word;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q == ARM) || (state_q == SHIFT) || (state_q == HOLD) || req_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Self-checking bench for spi_prog_loader (ADDR_WIDTH=2 so capacity is reachable).
module tb_spi_prog_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 2;
  localparam int          CAP = 1 << AW;
  localparam logic [31:0] END = 32'h0000_0FFF;

  logic          clk, rst, ss, mosi, gnt;
  logic          req, busy, done, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [AW:0]   wcnt;

  spi_prog_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .END_WORD  (END)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .spi_ss     (ss),
    .spi_mosi   (mosi),
    .mem_req_o  (req),
    .mem_gnt_i  (gnt),
    .mem_addr_o (addr),
    .mem_wdata_o(wdata),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .word_cnt_o (wcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: expected write stream plus when each flag must appear.
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t exp_q[$];
  int  m_accepted, m_retired;
  bit  m_done, m_err;
  int  m_done_cyc, m_err_cyc, exp_req_cyc;
  logic [AW-1:0] last_a;
  logic [31:0]   last_d;

  task automatic model_reset();
    exp_q.delete();
    m_accepted = 0;
    m_retired  = 0;
    m_done     = 0;
    m_err      = 0;
    m_done_cyc = 0;
    m_err_cyc  = 0;
    exp_req_cyc = -10;
  endtask

  task automatic set_err(input int t);
    if (!m_err) begin
      m_err     = 1;
      m_err_cyc = t;
    end
  endtask

  // A finished word becomes visible two edges after the last bit is driven.
  task automatic model_word(input logic [31:0] w);
    if (m_done) return;
    if (w == END) begin
      m_done     = 1;
      m_done_cyc = cyc + 2;
    end else if (m_accepted >= CAP || m_accepted > m_retired) begin
      set_err(cyc + 2);
    end else begin
      exp_q.push_back('{a: AW'(m_accepted), d: w});
      m_accepted++;
      exp_req_cyc = cyc + 2;
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("word_cnt", wcnt, m_retired);
      chk("done", done, (m_done && cyc >= m_done_cyc) ? 1 : 0);
      chk("err", err, (m_err && cyc >= m_err_cyc) ? 1 : 0);
      if (cyc == exp_req_cyc - 1) chk("req_early", req, 0);
      if (cyc == exp_req_cyc) chk("req_latency", req, 1);
      if (req) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_req: got req=1 want no pending write (cycle %0d)", cyc);
        end else begin
          chk("wr_addr", addr, exp_q[0].a);
          chk("wr_data", wdata, exp_q[0].d);
          if (gnt) begin
            last_a = exp_q[0].a;
            last_d = exp_q[0].d;
            void'(exp_q.pop_front());
            m_retired++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One frame: detect edge, ARM edge, nbits data bits, extra junk bits, then ss high.
  task automatic send_frame(input logic [31:0] w, input int nbits, input int extra);
    step(); ss = 1'b0; mosi = $urandom_range(0, 1) == 1;
    step(); mosi = $urandom_range(0, 1) == 1;
    chk("busy_frame", busy, m_done ? (exp_q.size() != 0) : 1);
    for (int i = 0; i < nbits; i++) begin
      step(); mosi = w[31-i];
      if (i == 31) model_word(w);
    end
    for (int i = 0; i < extra; i++) begin
      step(); mosi = $urandom_range(0, 1) == 1;
    end
    step(); ss = 1'b1; mosi = 1'b0;
    if (nbits < 32 && !m_done) set_err(cyc + 1);
    repeat (3) step();
    chk("busy_after", busy, exp_q.size() != 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", wcnt, 0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ss = 1'b1; mosi = 1'b0; gnt = 1'b0;
    model_reset();
    #1;
    chk("init_req", req, 0);
    chk("init_cnt", wcnt, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    step();

    // T1: three words then terminator, grant always on.
    gnt = 1'b1;
    send_frame(32'h1, 32, 0);
    send_frame(32'h2, 32, 0);
    send_frame(32'h3, 32, 0);
    send_frame(END, 32, 0);
    chk("t1_cnt", wcnt, 3);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_last", {last_a, last_d}, {2'd2, 32'h3});

    // T2: write stalled by grant low; second word is dropped.
    do_reset();
    gnt = 1'b0;
    send_frame(32'hA5A5A5A5, 32, 0);
    repeat (100) step();
    chk("t2_req", req, 1);
    chk("t2_wdata", wdata, 32'hA5A5A5A5);
    send_frame(32'h5A5A5A5A, 32, 0);
    chk("t2_err", err, 1);
    gnt = 1'b1;
    repeat (3) step();
    chk("t2_cnt", wcnt, 1);
    chk("t2_last", {last_a, last_d}, {2'd0, 32'hA5A5A5A5});

    // T3: truncated frame, then a good one.
    do_reset();
    send_frame(32'hDEADBEEF, 16, 0);
    send_frame(32'h12345678, 32, 0);
    chk("t3_err", err, 1);
    chk("t3_cnt", wcnt, 1);
    chk("t3_last", {last_a, last_d}, {2'd0, 32'h12345678});

    // T4: over-long frame, junk after the word is ignored.
    do_reset();
    send_frame(32'hCAFEF00D, 32, 6);
    chk("t4_err", err, 0);
    chk("t4_last", {last_a, last_d}, {2'd0, 32'hCAFEF00D});

    // T5: capacity of four words, fifth dropped; frames after terminator ignored.
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(32'h10 + 32'(i), 32, 0);
    chk("t5_cnt", wcnt, 4);
    chk("t5_err", err, 1);
    chk("t5_last", {last_a, last_d}, {2'd3, 32'h13});
    send_frame(END, 32, 0);
    send_frame(32'h99, 32, 0);
    chk("t5_done", done, 1);
    chk("t5_req", req, 0);
    chk("t5_cnt2", wcnt, 4);

    // T6: reset mid-shift and again with a write pending.
    do_reset();
    step(); ss = 1'b0;
    repeat (12) begin
      step(); mosi = $urandom_range(0, 1) == 1;
    end
    ss = 1'b1;
    do_reset();
    gnt = 1'b0;
    send_frame(32'h0BADF00D, 32, 0);
    chk("t6_pending", req, 1);
    do_reset();
    gnt = 1'b1;
    send_frame(32'h00000077, 32, 0);
    chk("t6_cnt", wcnt, 1);
    chk("t6_last", {last_a, last_d}, {2'd0, 32'h77});

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
